// File: rtl/dcfifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer controllers: Gray/binary
// conversion and depth computation.
package dcfifo_pkg;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic int ptr_width_of(input int addr_width);
    return addr_width + 1;
  endfunction

  // Operands are carried in 32 bits; only the low `width` bits are meaningful.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin, input int width);
    logic [31:0] masked;
    masked = bin & ((32'd1 << width) - 32'd1);
    return masked ^ (masked >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int width);
    logic [31:0] bin;
    bin = 32'd0;
    bin[width-1] = gray[width-1];
    for (int i = width - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/dcfifo_wr_ptr_ctrl.sv
// Write-domain pointer and flag controller: binary/Gray write pointer,
// RAM write strobe, and pessimistic full / almost-full / free-count flags.
module dcfifo_wr_ptr_ctrl
  import dcfifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   free_count
);

  localparam int PW    = ptr_width_of(ADDR_WIDTH);
  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [PW-1:0] wr_bin_r;
  logic [PW-1:0] wr_gray_r;
  logic          full_r;
  logic          almost_full_r;
  logic [PW-1:0] free_count_r;

  logic          accept_s;
  logic [PW-1:0] wr_bin_next_s;
  logic [PW-1:0] wr_gray_next_s;
  logic [PW-1:0] rd_bin_s;
  logic [PW-1:0] full_match_s;
  logic [PW-1:0] used_next_s;
  logic [PW-1:0] free_next_s;
  logic          full_next_s;
  logic          almost_full_next_s;

  // Write acceptance and next-state pointer/flag computation
  always_comb begin
    accept_s = wr_req & ~full_r & ~rst;
    if (accept_s) begin
      wr_bin_next_s = wr_bin_r + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wr_bin_next_s = wr_bin_r;
    end
    wr_gray_next_s = PW'(bin2gray(32'(wr_bin_next_s), PW));
    rd_bin_s       = PW'(gray2bin(32'(rd_ptr_gray_sync), PW));
    // Full when the writer is exactly one lap ahead: top two Gray bits inverted.
    full_match_s   = {~rd_ptr_gray_sync[PW-1:PW-2], rd_ptr_gray_sync[PW-3:0]};
    full_next_s    = (wr_gray_next_s == full_match_s);
    used_next_s    = wr_bin_next_s - rd_bin_s;
    free_next_s    = PW'(DEPTH) - used_next_s;
    almost_full_next_s = (free_next_s <= PW'(AF_THRESH));
  end

  // Pointer and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bin_r      <= {PW{1'b0}};
      wr_gray_r     <= {PW{1'b0}};
      full_r        <= 1'b0;
      almost_full_r <= 1'b0;
      free_count_r  <= PW'(DEPTH);
    end else begin
      wr_bin_r      <= wr_bin_next_s;
      wr_gray_r     <= wr_gray_next_s;
      full_r        <= full_next_s;
      almost_full_r <= almost_full_next_s;
      free_count_r  <= free_next_s;
    end
  end

  assign wr_en       = accept_s;
  assign wr_addr     = wr_bin_r[ADDR_WIDTH-1:0];
  assign wr_ptr_gray = wr_gray_r;
  assign full        = full_r;
  assign almost_full = almost_full_r;
  assign free_count  = free_count_r;

endmodule

// File: tb/tb_dcfifo_wr_ptr_ctrl.sv
// Directed, table-driven bench for dcfifo_wr_ptr_ctrl (ADDR_WIDTH=4, AF_THRESH=2).
module tb_dcfifo_wr_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_ptr_gray;
  logic [4:0] rd_ptr_gray_sync;
  logic       full;
  logic       almost_full;
  logic [4:0] free_count;

  int compared = 0;
  int mismatched = 0;

  dcfifo_wr_ptr_ctrl #(.ADDR_WIDTH(4), .AF_THRESH(2)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray_sync(rd_ptr_gray_sync),
    .full(full), .almost_full(almost_full), .free_count(free_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr_req;
    logic [4:0] rd_gray;
    logic       exp_wr_en;
    logic [3:0] exp_addr;
    logic [4:0] exp_gray;
    logic       exp_full;
    logic       exp_af;
    logic [4:0] exp_free;
  } vec_t;

  vec_t vecs[18];

  function automatic logic [4:0] g5(input int b);
    int m;
    m = b & 31;
    return 5'(m ^ (m >> 1));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wr_req = 1'b1;
    rd_ptr_gray_sync = 5'd0;
    @(posedge clk); #1;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_gray", int'(wr_ptr_gray), 0);
    chk("rst_addr", int'(wr_addr), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_free", int'(free_count), 16);
    chk("rst_af", int'(almost_full), 0);
    @(negedge clk);
    rst = 1'b0;
    wr_req = 1'b0;
  endtask

  // One cycle: drive at negedge, check strobe/address, then registered outputs.
  task automatic step(input logic req, input logic [4:0] rd, output logic en_seen);
    @(negedge clk);
    wr_req = req;
    rd_ptr_gray_sync = rd;
    #1;
    en_seen = wr_en;
    @(posedge clk); #1;
  endtask

  initial begin
    logic       en;
    logic [4:0] prev_gray;
    logic [3:0] addr_seen;
    rst = 1'b1;
    wr_req = 1'b0;
    rd_ptr_gray_sync = 5'd0;

    // Fill (16 writes), overflow attempt, then drain by one entry.
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{1'b1, 5'd0, 1'b1, 4'(i), g5(i + 1), (i == 15), ((15 - i) <= 2), 5'(15 - i)};
    end
    vecs[16] = '{1'b1, 5'b00000, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd0};
    vecs[17] = '{1'b0, 5'b00001, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b1, 5'd1};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      wr_req = vecs[i].wr_req;
      rd_ptr_gray_sync = vecs[i].rd_gray;
      #1;
      chk($sformatf("v%0d_wr_en", i), int'(wr_en), int'(vecs[i].exp_wr_en));
      chk($sformatf("v%0d_addr", i), int'(wr_addr), int'(vecs[i].exp_addr));
      @(posedge clk); #1;
      chk($sformatf("v%0d_gray", i), int'(wr_ptr_gray), int'(vecs[i].exp_gray));
      chk($sformatf("v%0d_full", i), int'(full), int'(vecs[i].exp_full));
      chk($sformatf("v%0d_af", i), int'(almost_full), int'(vecs[i].exp_af));
      chk($sformatf("v%0d_free", i), int'(free_count), int'(vecs[i].exp_free));
    end

    // Wrap: reader trails the writer by one entry across 40 writes.
    do_reset();
    prev_gray = 5'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      wr_req = 1'b1;
      rd_ptr_gray_sync = g5(i);
      #1;
      addr_seen = wr_addr;
      en = wr_en;
      @(posedge clk); #1;
      chk($sformatf("wrap%0d_addr", i), int'(addr_seen), i % 16);
      chk($sformatf("wrap%0d_wr_en", i), int'(en), 1);
      chk($sformatf("wrap%0d_gray", i), int'(wr_ptr_gray), int'(g5(i + 1)));
      chk($sformatf("wrap%0d_onebit", i), $countones(wr_ptr_gray ^ prev_gray), 1);
      chk($sformatf("wrap%0d_free", i), int'(free_count), 15);
      prev_gray = wr_ptr_gray;
    end

    // Simultaneous write and read advance, then read-only advance.
    do_reset();
    for (int i = 0; i < 11; i++) step(1'b1, 5'd0, en);
    chk("sim_pre_free", int'(free_count), 5);
    step(1'b1, g5(1), en);
    chk("sim_wr_en", int'(en), 1);
    chk("sim_free", int'(free_count), 5);
    chk("sim_gray", int'(wr_ptr_gray), int'(g5(12)));
    step(1'b0, g5(2), en);
    chk("rdonly_free", int'(free_count), 6);
    chk("rdonly_gray", int'(wr_ptr_gray), int'(g5(12)));

    // Mid-operation reset returns all state.
    do_reset();
    chk("post_rst_addr", int'(wr_addr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
